// File: rtl/regfile_wb_arbiter_pkg.sv
// Widths and constants shared by the register-file write-back arbiter,
// the register file itself and the decode stage.
package regfile_wb_arbiter_pkg;

  localparam int REG_ADR_W = 5;
  localparam int DATA_W    = 32;
  localparam int NUM_REGS  = 32;

  localparam logic [REG_ADR_W-1:0] REG_ZERO = 5'h0;

  // Port owner for the current cycle, exposed for debug and checkers.
  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_PIPE = 2'd1,
    SRC_HOLD = 2'd2,
    SRC_FORCE = 2'd3
  } wb_src_e;

endpackage

// File: rtl/regfile_wb_arbiter_wb_scoreboard.sv
// Busy scoreboard: one bit per architectural register that is waiting on a
// mul/div result. Set at issue, cleared when the result reaches the port.
module wb_scoreboard
  import regfile_wb_arbiter_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 set_valid_i,
  input  logic [REG_ADR_W-1:0] set_adr_i,
  input  logic                 clr_valid_i,
  input  logic [REG_ADR_W-1:0] clr_adr_i,
  input  logic [REG_ADR_W-1:0] q1_adr_i,
  input  logic [REG_ADR_W-1:0] q2_adr_i,
  output logic                 q1_busy_o,
  output logic                 q2_busy_o,
  output logic [NUM_REGS-1:0]  busy_o
);

  logic [NUM_REGS-1:0] busy_q, busy_d;

  // Next busy vector: clear first so a same-cycle set on the same address wins.
  always_comb begin
    busy_d = busy_q;
    if (clr_valid_i) busy_d[clr_adr_i] = 1'b0;
    if (set_valid_i && (set_adr_i != REG_ZERO)) busy_d[set_adr_i] = 1'b1;
    busy_d[0] = 1'b0;
  end

  // Busy vector register, wiped on reset.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) busy_q <= '0;
    else          busy_q <= busy_d;
  end

  // Queries read registered state only; a register draining now still reads busy.
  always_comb begin
    q1_busy_o = busy_q[q1_adr_i];
    q2_busy_o = busy_q[q2_adr_i];
  end

  assign busy_o = busy_q;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port between the pipeline write-back stage
// and a one-entry holding register for mul/div results, with anti-starvation.
//
// LValid/LReady handshake: a result transfers on a rising edge where both are
// high. The mul/div unit holds LWAdr/LDin stable while LValid is high and
// LReady is low; LValid never waits on LReady.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int MAX_WAIT = 4,
  parameter int CNT_W    = 4
) (
  input  logic                 Clk,
  input  logic                 Rst_n,
  input  logic                 PWE,
  input  logic [REG_ADR_W-1:0] PWAdr,
  input  logic [DATA_W-1:0]    PDin,
  input  logic                 LValid,
  input  logic [REG_ADR_W-1:0] LWAdr,
  input  logic [DATA_W-1:0]    LDin,
  output logic                 LReady,
  input  logic                 IssueValid,
  input  logic [REG_ADR_W-1:0] IssueWAdr,
  input  logic [REG_ADR_W-1:0] Q1Adr,
  input  logic [REG_ADR_W-1:0] Q2Adr,
  output logic                 Q1Busy,
  output logic                 Q2Busy,
  output logic                 Stall,
  output logic                 WE,
  output logic [REG_ADR_W-1:0] WAdr,
  output logic [DATA_W-1:0]    Din
);

  logic                 hold_valid_q;
  logic [REG_ADR_W-1:0] hold_adr_q;
  logic [DATA_W-1:0]    hold_data_q;
  logic [CNT_W-1:0]     wait_cnt_q;

  logic    preq;
  logic    force_hold;
  logic    hold_drive;
  wb_src_e src;
  logic [NUM_REGS-1:0] busy_dbg;

  // Request decode; r0 writes are dropped before arbitration.
  always_comb begin
    preq       = PWE && (PWAdr != REG_ZERO);
    force_hold = hold_valid_q && (wait_cnt_q == CNT_W'(MAX_WAIT));
    hold_drive = hold_valid_q && (force_hold || !preq);
    LReady     = Rst_n && !hold_valid_q;
  end

  // Port selection: forced hold, then pipeline, then opportunistic hold.
  always_comb begin
    src   = SRC_NONE;
    Stall = 1'b0;
    WE    = 1'b0;
    WAdr  = REG_ZERO;
    Din   = '0;
    if (force_hold) begin
      src   = SRC_FORCE;
      Stall = 1'b1;
      WE    = 1'b1;
      WAdr  = hold_adr_q;
      Din   = hold_data_q;
    end else if (preq) begin
      src  = SRC_PIPE;
      WE   = 1'b1;
      WAdr = PWAdr;
      Din  = PDin;
    end else if (hold_valid_q) begin
      src  = SRC_HOLD;
      WE   = 1'b1;
      WAdr = hold_adr_q;
      Din  = hold_data_q;
    end
  end

  // Holding register and wait counter: capture, age while losing, drain.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      hold_valid_q <= 1'b0;
      hold_adr_q   <= REG_ZERO;
      hold_data_q  <= '0;
      wait_cnt_q   <= '0;
    end else if (hold_drive) begin
      hold_valid_q <= 1'b0;
      wait_cnt_q   <= '0;
    end else if (hold_valid_q) begin
      if (wait_cnt_q != CNT_W'(MAX_WAIT)) wait_cnt_q <= wait_cnt_q + 1'b1;
    end else if (LValid && LReady) begin
      hold_valid_q <= 1'b1;
      hold_adr_q   <= LWAdr;
      hold_data_q  <= LDin;
    end
  end

  wb_scoreboard u_scoreboard (
    .clk_i       (Clk),
    .rst_n_i     (Rst_n),
    .set_valid_i (IssueValid),
    .set_adr_i   (IssueWAdr),
    .clr_valid_i (hold_drive),
    .clr_adr_i   (hold_adr_q),
    .q1_adr_i    (Q1Adr),
    .q2_adr_i    (Q2Adr),
    .q1_busy_o   (Q1Busy),
    .q2_busy_o   (Q2Busy),
    .busy_o      (busy_dbg)
  );

  // Debug taps for checkers: current port owner and the full busy vector.
  wb_src_e             dbg_src;
  logic [NUM_REGS-1:0] dbg_busy;
  assign dbg_src  = src;
  assign dbg_busy = busy_dbg;

endmodule
